apple_iie_timing_generator: RTL and testbench
=============================================

Name: apple_iie_timing_generator

Overview:
- Derives the Apple IIe motherboard timing from clk_14M: 7M, Q3, PHI0/PHI1, RAS_n/AX/CAS_n, CPU-cycle strobes and horizontal/vertical cycle counters.
- Sits directly downstream of the 14.318 MHz clock generator and upstream of the CPU core, memory and video stages of the motherboard.
- Every 65th CPU cycle is a long cycle (16 ticks of 14M instead of 14), matching IIe colour-burst alignment.

Parameters:
- CYCLES_PER_LINE, 65, CPU cycles per scan line; the last one (h = CYCLES_PER_LINE-1) is long.
- LINES_PER_FRAME, 262, scan lines per frame (312 for PAL builds).
- LONG_STRETCH, 2, extra 14M ticks appended to the long cycle.

Ports:
- clk_14M  input  1  14.318 MHz system clock; sole clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  run request; low requests a clean stop at a CPU-cycle boundary.
- clk_7M  output  1  14M/2.
- q3  output  1  asymmetric 2 MHz strobe.
- phi0  output  1  CPU clock phase 0.
- phi1  output  1  ~phi0.
- ras_n  output  1  DRAM row strobe, active low.
- ax  output  1  address mux select; 1 = row address.
- cas_n  output  1  DRAM column strobe, active low.
- phase  output  4  current tick within the CPU cycle, p.
- phi0_rise  output  1  1-tick pulse on the tick phi0 first reads 1.
- cycle_end  output  1  1-tick pulse on the last tick of a CPU cycle.
- hcount  output  7  CPU cycle within the line, 0..CYCLES_PER_LINE-1.
- vcount  output  9  line within the frame, 0..LINES_PER_FRAME-1.
- frame_start  output  1  1-tick pulse when p=0, h=0 and v=0 while running.
- running  output  1  1 in RUN state.

Behaviour:
- States:
  - STOPPED (reset state).
  - RUN.
  - STOPPING: running, stop pending.
- Reset (async, while reset_n=0): state STOPPED; p=0, h=0, v=0. Outputs are the stopped values: clk_7M=0, q3=0, ax=0, phi0=0, phi1=1, ras_n=1, cas_n=1, all pulses 0, running=0.
- Phase counter:
  - Last tick L = 13 on a normal cycle; L = 13+LONG_STRETCH on the long cycle (h = CYCLES_PER_LINE-1).
  - p increments each tick and wraps from L to 0.
- Counter wrap:
  - At p=L, h increments; h wraps from CYCLES_PER_LINE-1 to 0.
  - When h wraps, v increments; v wraps from LINES_PER_FRAME-1 to 0.
- Output table, all registered, valid in the same tick that phase shows p, while running:
  - clk_7M = p[0].
  - phi0 = 1 for p 7..L.
  - q3 = 1 for p 0..3 and 7..10.
  - ax = q3.
  - ras_n = 0 for p 2..6 and 9..L.
  - cas_n = 0 for p 4..6 and 11..L.
  - phi0_rise = (p==7).
  - cycle_end = (p==L).
- STOPPED -> RUN: enable sampled 1. The next tick has p=0 and outputs table(0). h and v resume from their held values.
- RUN -> STOPPING: enable sampled 0 while p<L. p keeps counting.
- STOPPING -> RUN: enable sampled 1 before p=L (stop cancelled); no gap in timing.
- Reaching STOPPED:
  - RUN or STOPPING with enable sampled 0 at p=L -> STOPPED.
  - h/v still advance on that last tick.
  - Outputs take the stopped values on the next tick.
- STOPPED: p, h and v hold; no pulses.
- A stop never truncates a CPU cycle, including the long cycle.
- Reset asserted mid-cycle: immediate return to the reset values; no completion of the cycle.

Test Plan:
- Release reset with enable=1 -> p sequence 0..13; phi0 0 for p 0..6 and 1 for p 7..13; q3 pattern 1111000111 1000 per tick; phi0_rise only at p=7.
- Run 65 cycles -> cycle at h=64 spans 16 ticks (p 0..15) with phi0, ras_n and cas_n stretched; line length 912 ticks; hcount wraps 64->0 and vcount 0->1.
- Run 262 lines -> vcount wraps 261->0; frame_start pulses once per 238,944 ticks.
- Drop enable at p=3 -> timing continues to p=13, then STOPPED: phi0=0, ras_n=1, q3=0, p held. Raise enable -> next tick p=0 with h advanced by 1.
- Pulse enable low at p=5 and high at p=8 -> no stop; cycle_end still at p=13; running stays 1.
- Assert reset_n=0 asynchronously at p=9 of cycle h=20 -> outputs drop to the reset values before the next edge; after release, p, h and v all restart from 0.

Source files
------------

// File: rtl/apple_iie_timing_generator_if.sv
// Timing bundle between the IIe timing generator and its consumers (CPU, DRAM, video).
// The generator drives everything except enable; dbg_state exposes the run/stop FSM.
interface apple_iie_timing_generator_if;
  logic       enable;
  logic       clk_7M;
  logic       q3;
  logic       phi0;
  logic       phi1;
  logic       ras_n;
  logic       ax;
  logic       cas_n;
  logic [3:0] phase;
  logic       phi0_rise;
  logic       cycle_end;
  logic [6:0] hcount;
  logic [8:0] vcount;
  logic       frame_start;
  logic       running;
  logic [1:0] dbg_state;

  modport master (
    input  enable,
    output clk_7M, q3, phi0, phi1, ras_n, ax, cas_n, phase, phi0_rise,
           cycle_end, hcount, vcount, frame_start, running, dbg_state
  );

  modport slave (
    output enable,
    input  clk_7M, q3, phi0, phi1, ras_n, ax, cas_n, phase, phi0_rise,
           cycle_end, hcount, vcount, frame_start, running, dbg_state
  );
endinterface

// File: rtl/apple_iie_timing_generator.sv
// Apple IIe motherboard timing from 14M: CPU phases, DRAM strobes, h/v cycle counters.
// Every CYCLES_PER_LINE-th CPU cycle is stretched by LONG_STRETCH ticks of 14M.
module apple_iie_timing_generator #(
  parameter int CYCLES_PER_LINE = 65,
  parameter int LINES_PER_FRAME = 262,
  parameter int LONG_STRETCH    = 2
) (
  input  logic                          clk_14M,
  input  logic                          reset_n,
  apple_iie_timing_generator_if.master  tg
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [3:0] LAST_NORMAL = 4'd13;
  localparam logic [3:0] LAST_LONG   = 4'(13 + LONG_STRETCH);
  localparam logic [6:0] H_LAST      = 7'(CYCLES_PER_LINE - 1);
  localparam logic [8:0] V_LAST      = 9'(LINES_PER_FRAME - 1);

  state_t     state_q, state_d;
  logic [3:0] p_q, p_d;
  logic [6:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  logic       clk7_q, clk7_d;
  logic       q3_q, q3_d;
  logic       phi0_q, phi0_d;
  logic       ras_n_q, ras_n_d;
  logic       cas_n_q, cas_n_d;
  logic       rise_q, rise_d;
  logic       cend_q, cend_d;
  logic       fstart_q, fstart_d;
  logic [3:0] last_cur;
  logic [3:0] last_nxt;
  logic       run_d;

  // Run/stop control and counters. A stop only takes effect on the last tick of a cycle.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    h_d      = h_q;
    v_d      = v_q;
    last_cur = (h_q == H_LAST) ? LAST_LONG : LAST_NORMAL;
    case (state_q)
      ST_STOPPED: begin
        if (tg.enable) state_d = ST_RUN;
      end
      ST_RUN, ST_STOPPING: begin
        if (p_q == last_cur) begin
          p_d = 4'd0;
          h_d = (h_q == H_LAST) ? 7'd0 : h_q + 7'd1;
          if (h_q == H_LAST) v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
          state_d = tg.enable ? ST_RUN : ST_STOPPED;
        end else begin
          p_d     = p_q + 4'd1;
          state_d = tg.enable ? ST_RUN : ST_STOPPING;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Output table is evaluated on the next tick's phase so the registered outputs line up with phase.
  always_comb begin
    run_d    = (state_d != ST_STOPPED);
    last_nxt = (h_d == H_LAST) ? LAST_LONG : LAST_NORMAL;
    clk7_d   = 1'b0;
    q3_d     = 1'b0;
    phi0_d   = 1'b0;
    ras_n_d  = 1'b1;
    cas_n_d  = 1'b1;
    rise_d   = 1'b0;
    cend_d   = 1'b0;
    fstart_d = 1'b0;
    if (run_d) begin
      clk7_d   = p_d[0];
      q3_d     = (p_d <= 4'd3) || ((p_d >= 4'd7) && (p_d <= 4'd10));
      phi0_d   = (p_d >= 4'd7);
      ras_n_d  = !(((p_d >= 4'd2) && (p_d <= 4'd6)) || (p_d >= 4'd9));
      cas_n_d  = !(((p_d >= 4'd4) && (p_d <= 4'd6)) || (p_d >= 4'd11));
      rise_d   = (p_d == 4'd7);
      cend_d   = (p_d == last_nxt);
      fstart_d = (p_d == 4'd0) && (h_d == 7'd0) && (v_d == 9'd0);
    end
  end

  always_ff @(posedge clk_14M or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_STOPPED;
      p_q      <= 4'd0;
      h_q      <= 7'd0;
      v_q      <= 9'd0;
      clk7_q   <= 1'b0;
      q3_q     <= 1'b0;
      phi0_q   <= 1'b0;
      ras_n_q  <= 1'b1;
      cas_n_q  <= 1'b1;
      rise_q   <= 1'b0;
      cend_q   <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      h_q      <= h_d;
      v_q      <= v_d;
      clk7_q   <= clk7_d;
      q3_q     <= q3_d;
      phi0_q   <= phi0_d;
      ras_n_q  <= ras_n_d;
      cas_n_q  <= cas_n_d;
      rise_q   <= rise_d;
      cend_q   <= cend_d;
      fstart_q <= fstart_d;
    end
  end

  assign tg.clk_7M      = clk7_q;
  assign tg.q3          = q3_q;
  assign tg.ax          = q3_q;
  assign tg.phi0        = phi0_q;
  assign tg.phi1        = ~phi0_q;
  assign tg.ras_n       = ras_n_q;
  assign tg.cas_n       = cas_n_q;
  assign tg.phase       = p_q;
  assign tg.phi0_rise   = rise_q;
  assign tg.cycle_end   = cend_q;
  assign tg.hcount      = h_q;
  assign tg.vcount      = v_q;
  assign tg.frame_start = fstart_q;
  assign tg.running     = (state_q != ST_STOPPED);
  assign tg.dbg_state   = state_q;

endmodule

// File: tb/tb_apple_iie_timing_generator.sv
// Self-checking bench: a tick-level reference model queues the expected output word for
// every clock; a negedge monitor pops and compares it against the DUT.
module tb_apple_iie_timing_generator;
  localparam int CPL = 65;
  localparam int LPF = 4;
  localparam int LS  = 2;

  logic clk_14M = 1'b0;
  logic reset_n;

  apple_iie_timing_generator_if tg_if ();

  apple_iie_timing_generator #(
    .CYCLES_PER_LINE (CPL),
    .LINES_PER_FRAME (LPF),
    .LONG_STRETCH    (LS)
  ) dut (
    .clk_14M (clk_14M),
    .reset_n (reset_n),
    .tg      (tg_if.master)
  );

  // clock / reset
  always #5 clk_14M = ~clk_14M;

  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q[$];

  // reference model: position in the raster and whether the CPU clock is running
  int m_p = 0;
  int m_h = 0;
  int m_v = 0;
  bit m_run = 1'b0;

  wire [30:0] dut_vec = {tg_if.clk_7M, tg_if.q3, tg_if.phi0, tg_if.phi1, tg_if.ras_n,
                         tg_if.ax, tg_if.cas_n, tg_if.phase, tg_if.phi0_rise,
                         tg_if.cycle_end, tg_if.hcount, tg_if.vcount,
                         tg_if.frame_start, tg_if.running};

  function automatic int cycle_len(int h);
    return (h == CPL - 1) ? 14 + LS : 14;
  endfunction

  function automatic logic [30:0] expect_vec(bit run, int p, int h, int v);
    logic c7, q3, phi0, ras_n, cas_n, rise, cend, fs;
    c7 = 0; q3 = 0; phi0 = 0; ras_n = 1; cas_n = 1; rise = 0; cend = 0; fs = 0;
    if (run) begin
      c7    = (p % 2) == 1;
      q3    = (p inside {[0:3], [7:10]});
      phi0  = (p >= 7);
      ras_n = !(p inside {[2:6]} || p >= 9);
      cas_n = !(p inside {[4:6]} || p >= 11);
      rise  = (p == 7);
      cend  = (p == cycle_len(h) - 1);
      fs    = (p == 0) && (h == 0) && (v == 0);
    end
    return {c7, q3, phi0, !phi0, ras_n, q3, cas_n, 4'(p), rise, cend, 7'(h), 9'(v), fs, run};
  endfunction

  task automatic model_step(input bit en);
    if (!m_run) begin
      if (en) m_run = 1'b1;
    end else if (m_p == cycle_len(m_h) - 1) begin
      m_p = 0;
      m_h = m_h + 1;
      if (m_h == CPL) begin
        m_h = 0;
        m_v = (m_v + 1) % LPF;
      end
      if (!en) m_run = 1'b0;
    end else begin
      m_p = m_p + 1;
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_h = 0; m_v = 0; m_run = 1'b0;
  endtask

  // driver: called at negedge+2, enable is sampled at the coming posedge
  task automatic tick(input bit en);
    tg_if.enable = en;
    model_step(en);
    exp_q.push_back(expect_vec(m_run, m_p, m_h, m_v));
    @(negedge clk_14M);
    #2;
  endtask

  task automatic check_reset(input string name);
    logic [30:0] e;
    e = expect_vec(1'b0, 0, 0, 0);
    checks++;
    if (dut_vec !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, dut_vec, e);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_14M) begin
    if (exp_q.size() > 0) begin
      logic [30:0] e;
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL tick t=%0t got %h expected %h", $time, dut_vec, e);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    tg_if.enable = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_14M);
    #2;
    check_reset("reset_values");

    reset_n = 1'b1;
    repeat (30) tick(1'b1);
    repeat (1100) tick(1'b1);

    // clean stop requested at p=3, then restart
    for (int i = 0; i < 40 && m_p != 3; i++) tick(1'b1);
    for (int i = 0; i < 20 && m_run; i++) tick(1'b0);
    repeat (5) tick(1'b0);
    repeat (30) tick(1'b1);

    // short enable glitch inside one cycle must not stop it
    for (int i = 0; i < 40 && m_p != 5; i++) tick(1'b1);
    repeat (3) tick(1'b0);
    repeat (20) tick(1'b1);

    for (int i = 0; i < 8000; i++) tick($urandom_range(0, 15) != 0);
    repeat (4000) tick(1'b1);

    // asynchronous reset in the middle of tick p=9 of cycle h=20
    for (int i = 0; i < 2000 && !(m_p == 9 && m_h == 20); i++) tick(1'b1);
    checks++;
    if (!(m_p == 9 && m_h == 20)) begin
      errors++;
      $display("FAIL reach_h20_p9 got p=%0d h=%0d expected p=9 h=20", m_p, m_h);
    end
    reset_n = 1'b0;
    #1;
    check_reset("async_reset");
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk_14M);
    #2;
    check_reset("reset_held");
    reset_n = 1'b1;
    repeat (40) tick(1'b1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
